usb2_sfifo_rd_master: RTL and testbench

USB2_SFIFO_RD_MASTER -- requirements
Module: usb2_sfifo_rd_master

---
 rtl/usb2_sfifo_pkg.sv | 14 +
 rtl/usb2_rx_fifo.sv | 57 +++++
 rtl/usb2_sfifo_rd_master.sv | 152 +++++++++++++++
 tb/tb_usb2_sfifo_rd_master.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/usb2_sfifo_pkg.sv
// Shared state encoding and bus width for the USB2 slave-FIFO read master.
package usb2_sfifo_pkg;

  localparam int BUS_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SEL   = 3'd1,
    ST_OE    = 3'd2,
    ST_READ  = 3'd3,
    ST_FLUSH = 3'd4
  } state_e;

endpackage

// File: rtl/usb2_rx_fifo.sv
// Synchronous show-ahead FIFO: the head word is visible on rdata_o whenever
// the FIFO is not empty, and reads as zero when it is empty.
module usb2_rx_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 16
) (
  input  logic                     usb_clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   free_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q;
  logic [AW:0]      rd_ptr_q;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign count   = wr_ptr_q - rd_ptr_q;
  assign full_o  = (count == DEPTH_C);
  assign empty_o = (count == '0);
  assign free_o  = DEPTH_C - count;
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge usb_clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
    end
  end

  always_ff @(posedge usb_clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
    end
  end

endmodule

// File: rtl/usb2_sfifo_rd_master.sv
// Reads XFER_WORDS words from a USB2 slave-FIFO endpoint into a stream output.
// Define USB2_SFIFO_RD_XSUM_EN to add the 16-bit running checksum port xsum.
module usb2_sfifo_rd_master
  import usb2_sfifo_pkg::*;
#(
  parameter int         XFER_WORDS = 256,
  parameter int         FIFO_DEPTH = 8,
  parameter logic [1:0] EP_ADDR    = 2'b00
) (
  input  logic             usb_clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             busy,
  output logic             done,
  input  logic             usb_flaga,
  input  logic [BUS_W-1:0] usb_fd_i,
  output logic [1:0]       usb_fifoaddr,
  output logic             usb_slcs,
  output logic             usb_sloe,
  output logic             usb_slrd,
  output logic             usb_slwr,
  output logic [BUS_W-1:0] m_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [15:0]      word_cnt
`ifdef USB2_SFIFO_RD_XSUM_EN
  ,
  output logic [15:0]      xsum
`endif
);

  localparam int          AW       = $clog2(FIFO_DEPTH);
  localparam logic [15:0] XFER_C   = 16'(XFER_WORDS);
  localparam logic [AW:0] FREE_MIN = (AW+1)'(2);

  state_e      state_q;
  logic        slcs_q;
  logic        sloe_q;
  logic        slrd_q;
  logic        done_q;
  logic [15:0] word_cnt_q;
  logic [15:0] word_cnt_d;
  logic        push;
  logic        pop;
  logic        rd_ok;
  logic        fifo_full;
  logic        fifo_empty;
  logic [AW:0] fifo_free;

  // A word lands on every edge where the read strobe was low in the prior cycle.
  assign push       = !slrd_q;
  assign pop        = m_valid && m_ready;
  assign word_cnt_d = word_cnt_q + {15'd0, push};

  // Two free slots cover the in-flight word plus the one this decision requests.
  assign rd_ok = usb_flaga && (fifo_free >= FREE_MIN) && (word_cnt_d < XFER_C);

  always_ff @(posedge usb_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      slcs_q     <= 1'b1;
      sloe_q     <= 1'b1;
      slrd_q     <= 1'b1;
      done_q     <= 1'b0;
      word_cnt_q <= '0;
    end else begin
      done_q     <= 1'b0;
      word_cnt_q <= word_cnt_d;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q    <= ST_SEL;
            slcs_q     <= 1'b0;
            word_cnt_q <= '0;
          end
        end
        ST_SEL: begin
          state_q <= ST_OE;
          sloe_q  <= 1'b0;
        end
        ST_OE: begin
          state_q <= ST_READ;
        end
        ST_READ: begin
          slrd_q <= !rd_ok;
          if (word_cnt_d == XFER_C) begin
            state_q <= ST_FLUSH;
            slcs_q  <= 1'b1;
            sloe_q  <= 1'b1;
            slrd_q  <= 1'b1;
          end
        end
        ST_FLUSH: begin
          if (fifo_empty) begin
            done_q  <= 1'b1;
            state_q <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          slcs_q  <= 1'b1;
          sloe_q  <= 1'b1;
          slrd_q  <= 1'b1;
        end
      endcase
    end
  end

  usb2_rx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (BUS_W)
  ) u_rx_fifo (
    .usb_clk (usb_clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .wdata_i (usb_fd_i),
    .pop_i   (pop),
    .rdata_o (m_data),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .free_o  (fifo_free)
  );

`ifdef USB2_SFIFO_RD_XSUM_EN
  logic [15:0] xsum_q;

  always_ff @(posedge usb_clk or negedge rst_n) begin
    if (!rst_n) begin
      xsum_q <= '0;
    end else if ((state_q == ST_IDLE) && start) begin
      xsum_q <= '0;
    end else if (push) begin
      xsum_q <= xsum_q + usb_fd_i;
    end
  end

  assign xsum = xsum_q;
`endif

  assign usb_fifoaddr = EP_ADDR;
  assign usb_slcs     = slcs_q;
  assign usb_sloe     = sloe_q;
  assign usb_slrd     = slrd_q;
  assign usb_slwr     = 1'b1;
  assign m_valid      = !fifo_empty;
  assign busy         = (state_q != ST_IDLE);
  assign done         = done_q;
  assign word_cnt     = word_cnt_q;

  no_overflow_a: assert property (@(posedge usb_clk) disable iff (!rst_n) !(push && fifo_full));

endmodule

// File: tb/tb_usb2_sfifo_rd_master.sv
// Bench for usb2_sfifo_rd_master: slave-FIFO device model with incrementing data,
// a stream scoreboard and table/sequence checks for a 256-word and a 1-word master.
module tb_usb2_sfifo_rd_master;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rstN;

  // 256-word instance
  logic        startA, busyA, doneA, flagaA, slcsA, sloeA, slrdA, slwrA;
  logic        mValidA, mReadyA;
  logic [1:0]  fifoaddrA;
  logic [15:0] mDataA, wordCntA;
  logic [15:0] devA = 16'd0;

  // 1-word instance
  logic        startB, busyB, doneB, flagaB, slcsB, sloeB, slrdB, slwrB;
  logic        mValidB, mReadyB;
  logic [1:0]  fifoaddrB;
  logic [15:0] mDataB, wordCntB;
  logic [15:0] devB = 16'd0;

`ifdef USB2_SFIFO_RD_XSUM_EN
  logic [15:0] xsumA, xsumB;
`endif

  usb2_sfifo_rd_master #(.XFER_WORDS(256), .FIFO_DEPTH(8), .EP_ADDR(2'b10)) dutA (
    .usb_clk(clk), .rst_n(rstN), .start(startA), .busy(busyA), .done(doneA),
    .usb_flaga(flagaA), .usb_fd_i(devA), .usb_fifoaddr(fifoaddrA),
    .usb_slcs(slcsA), .usb_sloe(sloeA), .usb_slrd(slrdA), .usb_slwr(slwrA),
    .m_data(mDataA), .m_valid(mValidA), .m_ready(mReadyA), .word_cnt(wordCntA)
`ifdef USB2_SFIFO_RD_XSUM_EN
    , .xsum(xsumA)
`endif
  );

  usb2_sfifo_rd_master #(.XFER_WORDS(1), .FIFO_DEPTH(4), .EP_ADDR(2'b00)) dutB (
    .usb_clk(clk), .rst_n(rstN), .start(startB), .busy(busyB), .done(doneB),
    .usb_flaga(flagaB), .usb_fd_i(devB), .usb_fifoaddr(fifoaddrB),
    .usb_slcs(slcsB), .usb_sloe(sloeB), .usb_slrd(slrdB), .usb_slwr(slwrB),
    .m_data(mDataB), .m_valid(mValidB), .m_ready(mReadyB), .word_cnt(wordCntB)
`ifdef USB2_SFIFO_RD_XSUM_EN
    , .xsum(xsumB)
`endif
  );

  // Device model: the bus shows the next word; a low read strobe at an edge advances it.
  always @(posedge clk) begin
    if (!slrdA && !slcsA) devA <= devA + 16'd1;
    if (!slrdB && !slcsB) devB <= devB + 16'd1;
  end

  int totalCnt = 0;
  int badCnt   = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    totalCnt++;
    if (actual !== expected) begin
      badCnt++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Scoreboard state for instance A: the stream must be consecutive device words.
  logic [15:0] nextExp = 16'd0;
  logic [15:0] xsumExp = 16'd0;
  int          popCnt  = 0;
  int          doneCnt = 0;
  int          slrdLowB = 0;
  int          doneCntB = 0;

  always @(negedge clk) begin : monA
    int occ;
    if (rstN === 1'b1) begin
      if (busyA) begin
        occ = int'(wordCntA) - popCnt;
        checkOutput("fifo_occupancy_in_range", 32'((occ >= 0) && (occ <= 8)), 32'd1);
        checkOutput("m_valid_vs_occupancy", 32'(mValidA), 32'(occ > 0));
      end
      checkOutput("word_cnt_max", 32'(wordCntA <= 16'd256), 32'd1);
      if (doneA) begin
        doneCnt++;
        checkOutput("done_all_popped", 32'(popCnt), 32'd256);
        checkOutput("done_word_cnt", 32'(wordCntA), 32'd256);
`ifdef USB2_SFIFO_RD_XSUM_EN
        checkOutput("done_xsum", 32'(xsumA), 32'(xsumExp));
`endif
      end
      if (mValidA && mReadyA) begin
        checkOutput("stream_data", 32'(mDataA), 32'(nextExp));
        xsumExp = xsumExp + nextExp;
        nextExp = nextExp + 16'd1;
        popCnt++;
      end
    end
  end

  always @(negedge clk) begin : monB
    if (rstN === 1'b1) begin
      if (!slrdB) slrdLowB++;
      if (doneB) doneCntB++;
    end
  end

  typedef struct {
    logic        start;
    logic        flaga;
    logic        mReady;
    logic        expSlcs;
    logic        expSloe;
    logic        expSlrd;
    logic        expBusy;
    logic        expValid;
    logic [15:0] expWordCnt;
  } vec_t;

  vec_t vecs[10];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input vec_t v);
    startA  = v.start;
    flagaA  = v.flaga;
    mReadyA = v.mReady;
  endtask

  task automatic driveMode(input int mode, input int cyc);
    case (mode)
      1: begin
        mReadyA = ((cyc % 4) == 0);
        flagaA  = 1'b1;
      end
      2: begin
        mReadyA = ($urandom_range(0, 3) != 0);
        flagaA  = ($urandom_range(0, 9) != 0);
      end
      default: begin
        mReadyA = 1'b1;
        flagaA  = 1'b1;
      end
    endcase
  endtask

  task automatic startTransfer();
    nextExp = devA;
    popCnt  = 0;
    xsumExp = 16'd0;
    startA  = 1'b1;
    tick();
    startA  = 1'b0;
  endtask

  task automatic finishTransfer(input int baseDone, input int mode, input int budget);
    int waited = 0;
    while ((doneCnt == baseDone) && (waited < budget)) begin
      driveMode(mode, waited);
      tick();
      waited++;
    end
    checkOutput("done_within_budget", 32'(doneCnt), 32'(baseDone + 1));
    mReadyA = 1'b1;
    flagaA  = 1'b1;
    tick();
    tick();
    checkOutput("done_single_pulse", 32'(doneCnt), 32'(baseDone + 1));
    checkOutput("busy_after_done", 32'(busyA), 32'd0);
    checkOutput("word_cnt_holds", 32'(wordCntA), 32'd256);
    checkOutput("words_popped", 32'(popCnt), 32'd256);
    checkOutput("fifo_drained", 32'(mValidA), 32'd0);
  endtask

  initial begin
    int base;
    int w;
    logic [15:0] cntAtDrop;

    //                 start flag rdy   slcs sloe slrd busy valid cnt
    vecs[0] = '{1'b1, 1'b0, 1'b1,  1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 16'd0};
    vecs[1] = '{1'b0, 1'b0, 1'b1,  1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'd0};
    vecs[2] = '{1'b0, 1'b0, 1'b1,  1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'd0};
    vecs[3] = '{1'b1, 1'b0, 1'b1,  1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'd0};
    vecs[4] = '{1'b0, 1'b1, 1'b1,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd0};
    vecs[5] = '{1'b0, 1'b1, 1'b1,  1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'd1};
    vecs[6] = '{1'b0, 1'b0, 1'b1,  1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 16'd2};
    vecs[7] = '{1'b0, 1'b0, 1'b1,  1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'd2};
    vecs[8] = '{1'b0, 1'b1, 1'b1,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd2};
    vecs[9] = '{1'b0, 1'b1, 1'b1,  1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'd3};

    rstN = 1'b1;
    startA = 1'b0; flagaA = 1'b0; mReadyA = 1'b0;
    startB = 1'b0; flagaB = 1'b1; mReadyB = 1'b0;
    #1 rstN = 1'b0;
    #3;
    checkOutput("rst_slcs", 32'(slcsA), 32'd1);
    checkOutput("rst_sloe", 32'(sloeA), 32'd1);
    checkOutput("rst_slrd", 32'(slrdA), 32'd1);
    checkOutput("rst_slwr", 32'(slwrA), 32'd1);
    checkOutput("rst_fifoaddr", 32'(fifoaddrA), 32'd2);
    checkOutput("rst_word_cnt", 32'(wordCntA), 32'd0);
    checkOutput("rst_m_valid", 32'(mValidA), 32'd0);
    checkOutput("rst_m_data", 32'(mDataA), 32'd0);
    checkOutput("rst_done", 32'(doneA), 32'd0);
    checkOutput("rst_busy", 32'(busyA), 32'd0);
`ifdef USB2_SFIFO_RD_XSUM_EN
    checkOutput("rst_xsum", 32'(xsumA), 32'd0);
`endif
    repeat (2) @(posedge clk);
    #1 rstN = 1'b1;
    tick();

    // Single-word transfer: one read strobe, done only after the word is popped.
    startB = 1'b1;
    tick();
    startB = 1'b0;
    repeat (30) tick();
    checkOutput("b_slrd_low_cycles", 32'(slrdLowB), 32'd1);
    checkOutput("b_m_valid", 32'(mValidB), 32'd1);
    checkOutput("b_m_data", 32'(mDataB), 32'd0);
    checkOutput("b_no_done_before_pop", 32'(doneCntB), 32'd0);
    checkOutput("b_word_cnt", 32'(wordCntB), 32'd1);
    checkOutput("b_busy_flush", 32'(busyB), 32'd1);
    mReadyB = 1'b1;
    w = 0;
    while ((doneCntB == 0) && (w < 10)) begin
      tick();
      w++;
    end
    tick();
    tick();
    checkOutput("b_done_once", 32'(doneCntB), 32'd1);
    checkOutput("b_busy_idle", 32'(busyB), 32'd0);
    checkOutput("b_word_cnt_hold", 32'(wordCntB), 32'd1);
    checkOutput("b_m_valid_empty", 32'(mValidB), 32'd0);
    checkOutput("b_slrd_still_once", 32'(slrdLowB), 32'd1);

    // Transfer 1: handshake table, then flag drop at word 100, then run to done.
    base = doneCnt;
    nextExp = devA;
    popCnt = 0;
    xsumExp = 16'd0;
    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i]);
      tick();
      checkOutput($sformatf("vec%0d_slcs", i), 32'(slcsA), 32'(vecs[i].expSlcs));
      checkOutput($sformatf("vec%0d_sloe", i), 32'(sloeA), 32'(vecs[i].expSloe));
      checkOutput($sformatf("vec%0d_slrd", i), 32'(slrdA), 32'(vecs[i].expSlrd));
      checkOutput($sformatf("vec%0d_busy", i), 32'(busyA), 32'(vecs[i].expBusy));
      checkOutput($sformatf("vec%0d_valid", i), 32'(mValidA), 32'(vecs[i].expValid));
      checkOutput($sformatf("vec%0d_word_cnt", i), 32'(wordCntA), 32'(vecs[i].expWordCnt));
    end
    startA = 1'b0;
    flagaA = 1'b1;
    mReadyA = 1'b1;
    w = 0;
    while ((wordCntA < 16'd100) && (w < 400)) begin
      tick();
      w++;
    end
    checkOutput("reach_word_100", 32'(wordCntA), 32'd100);
    cntAtDrop = wordCntA;
    flagaA = 1'b0;
    tick();
    checkOutput("drop_slrd_high", 32'(slrdA), 32'd1);
    checkOutput("drop_inflight_captured", 32'(wordCntA), 32'(cntAtDrop + 16'd1));
    for (int i = 0; i < 4; i++) begin
      tick();
      checkOutput("drop_slrd_hold", 32'(slrdA), 32'd1);
      checkOutput("drop_word_cnt_hold", 32'(wordCntA), 32'(cntAtDrop + 16'd1));
    end
    flagaA = 1'b1;
    finishTransfer(base, 0, 600);
`ifdef USB2_SFIFO_RD_XSUM_EN
    checkOutput("xsum_0_to_255", 32'(xsumA), 32'h7F80);
`endif

    // Transfer 2: consumer ready one cycle in four.
    base = doneCnt;
    startTransfer();
    finishTransfer(base, 1, 3000);

    // Transfer 3: random consumer backpressure and random flag drops.
    base = doneCnt;
    startTransfer();
    finishTransfer(base, 2, 3000);

    // Transfer 4: reset once word 50 is captured; no done may follow.
    base = doneCnt;
    mReadyA = 1'b1;
    flagaA = 1'b1;
    startTransfer();
    w = 0;
    while ((wordCntA < 16'd50) && (w < 200)) begin
      tick();
      w++;
    end
    checkOutput("reach_word_50", 32'(wordCntA), 32'd50);
    rstN = 1'b0;
    #1;
    checkOutput("arst_slcs", 32'(slcsA), 32'd1);
    checkOutput("arst_sloe", 32'(sloeA), 32'd1);
    checkOutput("arst_slrd", 32'(slrdA), 32'd1);
    checkOutput("arst_slwr", 32'(slwrA), 32'd1);
    checkOutput("arst_m_valid", 32'(mValidA), 32'd0);
    checkOutput("arst_m_data", 32'(mDataA), 32'd0);
    checkOutput("arst_busy", 32'(busyA), 32'd0);
    checkOutput("arst_word_cnt", 32'(wordCntA), 32'd0);
    tick();
    tick();
    rstN = 1'b1;
    repeat (5) tick();
    checkOutput("no_done_after_reset", 32'(doneCnt), 32'(base));

    // Transfer 5: restart reads on from the device's current word.
    base = doneCnt;
    startTransfer();
    finishTransfer(base, 0, 600);

    $display("test done: total=%0d bad=%0d", totalCnt, badCnt);
    $finish;
  end

endmodule
